multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle control FSM that sequences one instruction at a time through the core datapath: instruction fetch over a req/ack memory handshake, instruction-register capture, execute, optional data-memory access, register writeback, then a single program-counter update. It owns the PC `LOAD` strobe and the instruction-register load. Branch/next-PC selection stays in the PC block. This controller only decides *when* the PC advances. It also retires a committed-instruction counter and traps on memory timeout.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 15: cycles with ack low tolerated in FETCH or MEM before ERROR (1..255).
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `CLK` in 1: single clock; all state updates on rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `start` in 1: leaves IDLE when high.
- `opcode` in 7: opcode field of the instruction register; valid from DECODE onward.
- `imem_ack` in 1: instruction memory ack; data valid in the same cycle.
- `dmem_ack` in 1: data memory ack.
- `imem_req` out 1: instruction fetch request.
- `dmem_req` out 1: data memory request.
- `dmem_we` out 1: data memory write enable; valid with `dmem_req`.
- `ir_load` out 1: instruction-register capture strobe.
- `reg_write` out 1: register-file write enable.
- `pc_load` out 1: PC `LOAD` strobe.
- `busy` out 1: high in every state except IDLE, HALT and ERROR.
- `halted` out 1: high in HALT.
- `error` out 1: high in ERROR.
- `instret` out CNT_W: count of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, UPDATE, HALT, ERROR. All outputs are Moore-decoded from state, except `ir_load`.
- IDLE: goes to FETCH when `start`=1, else stays. `start` is ignored in all other states.
- FETCH:
  - `imem_req`=1 for the whole state.
  - `ir_load` = FETCH & `imem_ack`, which is combinational.
  - On ack, go to DECODE.
- DECODE: latch the instruction class from `opcode` into an internal register.
  - `0000011` = LOAD
  - `0100011` = STORE
  - `1100011` = BRANCH
  - `1110011` = SYSTEM
  - anything else = ALU
  - Next state: SYSTEM goes to HALT; all other classes go to EXEC.
- EXEC: one cycle. Next state is MEM for LOAD/STORE, UPDATE for BRANCH, WB for ALU.
- MEM:
  - `dmem_req`=1; `dmem_we`=1 only for STORE.
  - On `dmem_ack`, LOAD goes to WB and STORE goes to UPDATE.
- WB: `reg_write`=1 for one cycle, then UPDATE.
- UPDATE: `pc_load`=1 for one cycle. `instret` increments by 1, wrapping to 0 after all-ones. Then FETCH.
- HALT and ERROR are terminal: all requests and strobes are low, and only `RST` exits. The SYSTEM instruction is not retired.
- Timeout:
  - A wait counter clears on entry to FETCH/MEM and increments each cycle the relevant ack is low.
  - When the counter equals MEM_TIMEOUT with ack still low, go to ERROR on that edge.
  - An ack arriving in the same cycle the counter reaches MEM_TIMEOUT wins: normal transition, no error.
- Acks in states that are not requesting are ignored.

## Timing
- Reset values:
  - state = IDLE
  - `instret`=0, wait counter = 0, class = ALU
  - all strobes and requests = 0
  - `busy`=`halted`=`error`=0
- `RST` mid-transaction drops `imem_req`/`dmem_req` asynchronously. No partial `pc_load` or `reg_write` pulse survives reset.
- Latency with zero-wait memory (ack in the first request cycle), counting FETCH through UPDATE:
  - ALU: 5 cycles
  - BRANCH: 4 cycles
  - STORE: 5 cycles
  - LOAD: 6 cycles
- Each memory wait cycle adds 1 cycle.
- `pc_load` and `reg_write` are exactly one cycle wide. There is exactly one `pc_load` per retired instruction, and it occurs after any `reg_write` for that instruction.
- `imem_req` and `dmem_req` are never high simultaneously.
- From `start` sampled high in IDLE, `imem_req` rises the next cycle.
- Worst-case timeout: ERROR is entered MEM_TIMEOUT+1 cycles after FETCH/MEM entry.

## Test plan
- Reset and ALU run:
  - Stimulus: RST, then `start`=1 for 1 cycle, zero-wait imem, `opcode`=`0110011` repeated.
  - Response: `pc_load` every 5 cycles; `reg_write` 1 cycle before each `pc_load`; `instret` = 3 after the third UPDATE.
- LOAD with dmem wait:
  - Stimulus: `opcode`=`0000011`, `dmem_ack` delayed 3 cycles.
  - Response: `dmem_req` high for 4 cycles with `dmem_we`=0; then WB, then UPDATE; total 9 cycles.
- STORE then BRANCH:
  - Response: STORE gives `dmem_we`=1 with no `reg_write` in 5 cycles; BRANCH gives `pc_load` 4 cycles after its FETCH with no `reg_write`.
- Timeout:
  - Stimulus: MEM_TIMEOUT=3, `imem_ack` held 0.
  - Response: `error`=1 at the 5th cycle after FETCH entry; `imem_req`=0; `instret` frozen; `start` ignored.
- Boundary ack:
  - Stimulus: ack arrives exactly in the counter-equals-3 cycle.
  - Response: no error; normal DECODE.
- HALT and async reset:
  - Stimulus: `opcode`=`1110011` after 2 ALU instructions.
  - Response: `halted`=1, `instret`=2, no `pc_load`.
  - Stimulus: RST asserted between clock edges during a MEM wait.
  - Response: `dmem_req` falls immediately; state returns to IDLE.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, optional data
// access, writeback and a single PC update per instruction, with memory timeout trap.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [6:0]       opcode,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_load,
  output logic             reg_write,
  output logic             pc_load,
  output logic             busy,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       dbg_state
);

  // Memory handshake: a request stays high until the cycle its ack is sampled
  // high; that cycle completes the transfer. Acks outside a request are ignored.

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_UPDATE, S_HALT, S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH, C_SYSTEM
  } iclass_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state;
  state_t     state_nxt;
  iclass_t    iclass;
  iclass_t    decoded;
  logic [7:0] wait_cnt;

  function automatic iclass_t decode_class(input logic [6:0] op);
    case (op)
      7'b0000011: decode_class = C_LOAD;
      7'b0100011: decode_class = C_STORE;
      7'b1100011: decode_class = C_BRANCH;
      7'b1110011: decode_class = C_SYSTEM;
      default:    decode_class = C_ALU;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    decoded   = decode_class(opcode);
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        // An ack in the final tolerated cycle still completes normally.
        if (imem_ack)                 state_nxt = S_DECODE;
        else if (wait_cnt == TIMEOUT) state_nxt = S_ERROR;
      end
      S_DECODE: state_nxt = (decoded == C_SYSTEM) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (iclass)
          C_LOAD, C_STORE: state_nxt = S_MEM;
          C_BRANCH:        state_nxt = S_UPDATE;
          default:         state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ack)                 state_nxt = (iclass == C_LOAD) ? S_WB : S_UPDATE;
        else if (wait_cnt == TIMEOUT) state_nxt = S_ERROR;
      end
      S_WB:     state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      S_ERROR:  state_nxt = S_ERROR;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs are registered from the next state so they line up with the
  // state they belong to and clear asynchronously with RST.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      iclass    <= C_ALU;
      wait_cnt  <= 8'd0;
      instret   <= '0;
      imem_req  <= 1'b0;
      dmem_req  <= 1'b0;
      dmem_we   <= 1'b0;
      reg_write <= 1'b0;
      pc_load   <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      error     <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == S_DECODE) iclass <= decoded;

      if ((state_nxt == S_FETCH || state_nxt == S_MEM) && state_nxt != state)
        wait_cnt <= 8'd0;
      else if ((state == S_FETCH && !imem_ack) || (state == S_MEM && !dmem_ack))
        wait_cnt <= wait_cnt + 8'd1;

      if (state == S_UPDATE) instret <= instret + CNT_W'(1);

      imem_req  <= (state_nxt == S_FETCH);
      dmem_req  <= (state_nxt == S_MEM);
      dmem_we   <= (state_nxt == S_MEM) && (iclass == C_STORE);
      reg_write <= (state_nxt == S_WB);
      pc_load   <= (state_nxt == S_UPDATE);
      busy      <= !(state_nxt == S_IDLE || state_nxt == S_HALT || state_nxt == S_ERROR);
      halted    <= (state_nxt == S_HALT);
      error     <= (state_nxt == S_ERROR);
    end
  end

  assign ir_load   = (state == S_FETCH) & imem_ack;
  assign dbg_state = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: random instruction stream with a memory
// responder, a latency/strobe reference model and a retire-order scoreboard.
module tb_multicycle_control;

  localparam int T     = 3;
  localparam int CW    = 8;
  localparam int EXP_W = 8 + 2 + 1 + 2 + 1;

  logic          CLK;
  logic          RST;
  logic          start;
  logic [6:0]    opcode;
  logic          imem_ack;
  logic          dmem_ack;
  logic          imem_req;
  logic          dmem_req;
  logic          dmem_we;
  logic          ir_load;
  logic          reg_write;
  logic          pc_load;
  logic          busy;
  logic          halted;
  logic          error;
  logic [CW-1:0] instret;
  logic [3:0]    dbg_state;

  multicycle_control #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .opcode(opcode),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_load(ir_load), .reg_write(reg_write), .pc_load(pc_load),
    .busy(busy), .halted(halted), .error(error),
    .instret(instret), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- shared state ----------------
  typedef struct packed {
    logic [6:0] op;
    logic [7:0] iw;   // imem wait cycles, 255 = never ack
    logic [7:0] dw;   // dmem wait cycles, 255 = never ack
  } instr_t;

  instr_t           prog[$];
  instr_t           cur;
  logic [EXP_W-1:0] exp_q[$];
  logic [CW-1:0]    cnt_q[$];
  int               total;
  int               bad;
  int               model_cnt;
  int               cyc;
  int               req_start;
  int               err_delay;

  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  // 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 SYSTEM
  function automatic int cls_of(input logic [6:0] op);
    if (op == OP_LD) return 1;
    if (op == OP_ST) return 2;
    if (op == OP_BR) return 3;
    if (op == OP_SYS) return 4;
    return 0;
  endfunction

  // Reference model: cycles from first fetch cycle through the PC update.
  task automatic issue(input instr_t i);
    int  c;
    int  lat;
    bit  mem;
    c   = cls_of(i.op);
    mem = (c == 1 || c == 2);
    if (c == 4) return;
    if (i.iw == 8'd255 || (mem && i.dw == 8'd255)) return;
    case (c)
      1:       lat = 6;
      3:       lat = 4;
      default: lat = 5;
    endcase
    lat = lat + int'(i.iw) + (mem ? int'(i.dw) : 0);
    model_cnt++;
    exp_q.push_back({8'(lat), 2'((c == 0 || c == 1) ? 1 : 0), (c == 2), 2'd1, 1'b0});
    cnt_q.push_back(CW'(model_cnt));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder (driver) ----------------
  initial begin : responder
    int icnt;
    int dcnt;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    opcode   = OP_ALU;
    icnt     = 0;
    dcnt     = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        icnt = 0; dcnt = 0; imem_ack = 1'b0; dmem_ack = 1'b0;
      end else begin
        if (imem_req) begin
          if (icnt == 0) begin
            if (prog.size() == 0) begin
              $display("FAIL prog_empty: fetch with no instruction queued");
              $fatal(1, "instruction stream exhausted");
            end
            cur = prog.pop_front();
            issue(cur);
          end
          if (cur.iw != 8'd255 && icnt == int'(cur.iw)) begin
            imem_ack = 1'b1;
            opcode   = cur.op;
          end else begin
            imem_ack = 1'b0;
          end
          icnt++;
        end else begin
          icnt     = 0;
          imem_ack = 1'($urandom_range(0, 1));
        end
        if (dmem_req) begin
          dmem_ack = (cur.dw != 8'd255 && dcnt == int'(cur.dw));
          dcnt++;
        end else begin
          dcnt     = 0;
          dmem_ack = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int               lat;
    int               rw_n;
    int               irl_n;
    bit               we_seen;
    bit               ovl;
    bit               p_ireq;
    bit               p_dreq;
    bit               p_err;
    bit               pend;
    logic [CW-1:0]    pend_cnt;
    logic [EXP_W-1:0] act;
    logic [EXP_W-1:0] e;
    lat = 0; rw_n = 0; irl_n = 0; we_seen = 0; ovl = 0;
    p_ireq = 0; p_dreq = 0; p_err = 0; pend = 0; pend_cnt = '0;
    cyc = 0; req_start = 0; err_delay = -1;
    forever begin
      @(negedge CLK);
      #1;
      cyc++;
      if (RST) begin
        lat = 0; rw_n = 0; irl_n = 0; we_seen = 0; ovl = 0;
        p_ireq = 0; p_dreq = 0; p_err = 0; pend = 0;
      end else begin
        if (pend) begin
          total++;
          if (instret !== pend_cnt) begin
            bad++;
            $display("FAIL instret_after_update: got %0d expected %0d", instret, pend_cnt);
          end
          pend = 0;
        end
        if ((imem_req && !p_ireq) || (dmem_req && !p_dreq)) req_start = cyc;
        if (imem_req && !p_ireq) begin
          lat = 0; rw_n = 0; irl_n = 0; we_seen = 0; ovl = 0;
        end
        lat++;
        if (reg_write) rw_n++;
        if (ir_load) irl_n++;
        if (dmem_req && dmem_we) we_seen = 1;
        if (imem_req && dmem_req) ovl = 1;
        if (error && !p_err) err_delay = cyc - req_start;
        if (pc_load) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pc_load: pc_load with nothing expected, cycle %0d", cyc);
          end else begin
            e   = exp_q.pop_front();
            act = {8'(lat), 2'(rw_n), we_seen, 2'(irl_n), ovl};
            if (act !== e) begin
              bad++;
              $display("FAIL retire: got lat=%0d rw=%0d we=%0d irl=%0d ovl=%0d expected lat=%0d rw=%0d we=%0d irl=%0d ovl=%0d",
                       act[13:6], act[5:4], act[3], act[2:1], act[0],
                       e[13:6], e[5:4], e[3], e[2:1], e[0]);
            end
            pend_cnt = cnt_q.pop_front();
            pend     = 1;
          end
        end
        p_ireq = imem_req;
        p_dreq = dmem_req;
        p_err  = error;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    prog.delete();
    exp_q.delete();
    cnt_q.delete();
    model_cnt = 0;
    err_delay = -1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_error(input string name);
    int n;
    n = 0;
    while (!error && n < 200) begin
      @(negedge CLK);
      n++;
    end
    #2;
    chk(name, 32'(error), 32'd1);
  endtask

  function automatic instr_t mk(input logic [6:0] op, input int iw, input int dw);
    mk = '{op: op, iw: 8'(iw), dw: 8'(dw)};
  endfunction

  initial begin : main
    instr_t r;
    int     n;
    int     k;
    RST = 1'b1; start = 1'b0;
    total = 0; bad = 0; model_cnt = 0;

    repeat (2) @(negedge CLK);
    #2;
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_halted",    32'(halted),    32'd0);
    chk("rst_error",     32'(error),     32'd0);
    chk("rst_imem_req",  32'(imem_req),  32'd0);
    chk("rst_dmem_req",  32'(dmem_req),  32'd0);
    chk("rst_dmem_we",   32'(dmem_we),   32'd0);
    chk("rst_pc_load",   32'(pc_load),   32'd0);
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    chk("rst_ir_load",   32'(ir_load),   32'd0);
    chk("rst_instret",   32'(instret),   32'd0);

    // Directed head, random body long enough to wrap the counter, then SYSTEM.
    prog.push_back(mk(OP_ALU, 0, 0));
    prog.push_back(mk(OP_ALU, 0, 0));
    prog.push_back(mk(OP_ALU, 0, 0));
    prog.push_back(mk(OP_LD,  0, 3));
    prog.push_back(mk(OP_ST,  0, 0));
    prog.push_back(mk(OP_BR,  0, 0));
    prog.push_back(mk(OP_ALU, 3, 0));
    prog.push_back(mk(OP_ST,  2, 3));
    for (int i = 0; i < 260; i++) begin
      k = $urandom_range(0, 3);
      case (k)
        0: begin
          r.op = 7'($urandom_range(0, 127));
          if (cls_of(r.op) != 0) r.op = OP_ALU;
        end
        1: r.op = OP_LD;
        2: r.op = OP_ST;
        default: r.op = OP_BR;
      endcase
      r.iw = 8'($urandom_range(0, T));
      r.dw = 8'($urandom_range(0, T));
      prog.push_back(r);
    end
    prog.push_back(mk(OP_SYS, 1, 0));

    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    start = 1'b1;
    #2;
    chk("req_before_start_edge", 32'(imem_req), 32'd0);
    @(negedge CLK);
    start = 1'b0;
    #2;
    chk("req_after_start", 32'(imem_req), 32'd1);

    n = 0;
    while (!halted && n < 20000) begin
      @(negedge CLK);
      n++;
    end
    #2;
    chk("halted",          32'(halted),      32'd1);
    chk("halt_instret",    32'(instret),     32'(CW'(model_cnt)));
    chk("halt_all_retired", 32'(exp_q.size()), 32'd0);
    chk("halt_busy",       32'(busy),        32'd0);
    start = 1'b1;
    repeat (3) @(negedge CLK);
    start = 1'b0;
    #2;
    chk("halt_start_ignored", 32'(halted),  32'd1);
    chk("halt_instret_hold",  32'(instret), 32'(CW'(model_cnt)));

    // Fetch timeout after one retired instruction.
    do_reset();
    prog.push_back(mk(OP_ALU, 0, 0));
    prog.push_back(mk(OP_ALU, 255, 0));
    pulse_start();
    wait_error("imem_timeout_error");
    chk("imem_timeout_delay", 32'(err_delay), 32'(T + 1));
    chk("imem_timeout_req",   32'(imem_req),  32'd0);
    chk("imem_timeout_busy",  32'(busy),      32'd0);
    chk("imem_timeout_cnt",   32'(instret),   32'd1);
    start = 1'b1;
    repeat (2) @(negedge CLK);
    start = 1'b0;
    #2;
    chk("error_start_ignored", 32'(error),    32'd1);
    chk("error_instret_hold",  32'(instret),  32'd1);
    chk("error_no_req",        32'(imem_req | dmem_req), 32'd0);

    // Data-memory timeout on a LOAD.
    do_reset();
    prog.push_back(mk(OP_LD, 1, 255));
    pulse_start();
    wait_error("dmem_timeout_error");
    chk("dmem_timeout_delay", 32'(err_delay), 32'(T + 1));
    chk("dmem_timeout_req",   32'(dmem_req),  32'd0);
    chk("dmem_timeout_cnt",   32'(instret),   32'd0);

    // Asynchronous reset in the middle of a STORE data wait.
    do_reset();
    prog.push_back(mk(OP_ST, 0, 255));
    pulse_start();
    n = 0;
    while (!dmem_req && n < 50) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    #2;
    chk("store_wait_req", 32'(dmem_req), 32'd1);
    chk("store_wait_we",  32'(dmem_we),  32'd1);
    RST = 1'b1;
    #1;
    chk("async_rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("async_rst_dmem_we",  32'(dmem_we),  32'd0);
    chk("async_rst_busy",     32'(busy),     32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    #2;
    chk("post_rst_idle_busy",  32'(busy),     32'd0);
    chk("post_rst_idle_req",   32'(imem_req), 32'd0);
    chk("post_rst_no_error",   32'(error),    32'd0);
    chk("post_rst_instret",    32'(instret),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
